// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF      = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  // Per-cycle stage-register control vector, MSB first.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

  // Control for one advance cycle; mem_wait already includes whether the
  // memory-wait rule is honoured this cycle.
  function automatic ctrl_t advance_ctrl(input logic mem_wait,
                                         input logic branch,
                                         input logic load_use);
    ctrl_t c;
    c = CTRL_OFF;
    if (mem_wait) begin
      c.mem_wb_en     = 1'b1;
      c.mem_wb_bubble = 1'b1;
    end else begin
      c.pc_en     = 1'b1;
      c.if_id_en  = 1'b1;
      c.id_ex_en  = 1'b1;
      c.ex_mem_en = 1'b1;
      c.mem_wb_en = 1'b1;
      if (branch) begin
        c.if_id_flush  = 1'b1;
        c.id_ex_bubble = 1'b1;
      end else if (load_use) begin
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_bubble = 1'b1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with asynchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, hold at all-ones.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch flushes,
// data-memory waits and debug halt/step, plus stall/flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  id_ex_memread,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  mem_wb_bubble,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  state_t state_q, state_d;
  logic   ret_halt_q, ret_halt_d;
  ctrl_t  ctrl_c;
  logic   halted_c;
  logic   load_use_c;
  logic   mem_wait_c;
  logic   stall_inc_c;

  assign load_use_c = id_ex_memread && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  assign mem_wait_c = dmem_req && !dmem_ready;

  // State and MEM_WAIT return target.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_RUN;
      ret_halt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_halt_q <= ret_halt_d;
    end
  end

  // Next state and same-cycle stage control.
  always_comb begin
    ctrl_c     = CTRL_OFF;
    halted_c   = 1'b0;
    state_d    = state_q;
    ret_halt_d = ret_halt_q;
    unique case (state_q)
      ST_RUN: begin
        ctrl_c     = advance_ctrl(mem_wait_c, branch_taken, load_use_c);
        ret_halt_d = 1'b0;
        if (mem_wait_c)    state_d = ST_MEM_WAIT;
        else if (halt_req) state_d = ST_HALT;
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl_c = advance_ctrl(1'b1, 1'b0, 1'b0);
        end else begin
          // Release cycle: the wait is over, so only branch/load-use apply.
          ctrl_c     = advance_ctrl(1'b0, branch_taken, load_use_c);
          state_d    = ret_halt_q ? ST_HALT : ST_RUN;
          ret_halt_d = 1'b0;
        end
      end
      ST_HALT: begin
        halted_c = 1'b1;
        if (step_req) begin
          ctrl_c = advance_ctrl(mem_wait_c, branch_taken, load_use_c);
          if (mem_wait_c) begin
            ret_halt_d = 1'b1;
            state_d    = ST_MEM_WAIT;
          end
        end else if (!halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        ret_halt_d = 1'b0;
      end
    endcase
    if (arst) begin
      ctrl_c   = CTRL_OFF;
      halted_c = 1'b0;
    end
  end

  assign pc_en         = ctrl_c.pc_en;
  assign if_id_en      = ctrl_c.if_id_en;
  assign id_ex_en      = ctrl_c.id_ex_en;
  assign ex_mem_en     = ctrl_c.ex_mem_en;
  assign mem_wb_en     = ctrl_c.mem_wb_en;
  assign if_id_flush   = ctrl_c.if_id_flush;
  assign id_ex_bubble  = ctrl_c.id_ex_bubble;
  assign mem_wb_bubble = ctrl_c.mem_wb_bubble;
  assign halted        = halted_c;

  // A debug halt is not a stall; frozen cycles elsewhere are.
  assign stall_inc_c = !ctrl_c.pc_en && (state_q != ST_HALT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .arst  (arst),
    .inc   (stall_inc_c),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .arst  (arst),
    .inc   (ctrl_c.if_id_flush),
    .count (flush_cnt)
  );

endmodule
